// File: rtl/reaction_score_keeper.sv
// Reaction-timer score keeper: accepts a 3-digit BCD result, range-checks it,
// compares it digit-serially against the stored best and updates best time,
// new-record / rejected flags and a saturating 2-digit BCD attempt counter.
module reaction_score_keeper #(
   parameter logic [11:0] MIN_VALID_BCD = 12'h010,
   parameter logic [7:0]  ATTEMPT_MAX   = 8'h99
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       res_valid,
   output logic       res_ready,
   input  logic [3:0] res_d2,
   input  logic [3:0] res_d1,
   input  logic [3:0] res_d0,
   input  logic       clear_best,
   output logic [3:0] best_d2,
   output logic [3:0] best_d1,
   output logic [3:0] best_d0,
   output logic       best_valid,
   output logic       new_record,
   output logic       rejected,
   output logic [3:0] attempts_d1,
   output logic [3:0] attempts_d0
);

   typedef enum logic [2:0] {StIdle, StCheck, StCmp2, StCmp1, StCmp0, StCommit} state_e;
   typedef enum logic [1:0] {VerdUndec, VerdLess, VerdGreater} verdict_e;

   state_e      state_q, state_d;
   verdict_e    verdict_q, verdict_d;
   logic [11:0] cap_q, cap_d;
   logic [11:0] best_q, best_d;
   logic        best_valid_q, best_valid_d;
   logic        new_record_q, new_record_d;
   logic        rejected_q, rejected_d;
   logic [7:0]  attempts_q, attempts_d;
   logic        range_bad;

   // First differing digit (MSD first) decides; later digits cannot override it.
   function automatic verdict_e judge(input verdict_e v, input logic [3:0] c, input logic [3:0] b);
      if (v != VerdUndec) return v;
      if (c < b) return VerdLess;
      if (c > b) return VerdGreater;
      return VerdUndec;
   endfunction

   // Per-digit BCD increment that holds at the saturation value.
   function automatic logic [7:0] bcd_inc(input logic [7:0] v);
      if (v == ATTEMPT_MAX) return v;
      if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
      return {v[7:4], v[3:0] + 4'd1};
   endfunction

   assign res_ready = (state_q == StIdle);

   // BCD concatenation orders like the decimal value once every digit is 0-9.
   assign range_bad = (cap_q[11:8] > 4'd9) | (cap_q[7:4] > 4'd9) | (cap_q[3:0] > 4'd9) |
                      (cap_q < MIN_VALID_BCD);

   // Next-state and datapath update; clear_best overrides the sequencer.
   always_comb begin
      state_d      = state_q;
      verdict_d    = verdict_q;
      cap_d        = cap_q;
      best_d       = best_q;
      best_valid_d = best_valid_q;
      new_record_d = new_record_q;
      rejected_d   = rejected_q;
      attempts_d   = attempts_q;
      if (clear_best) begin
         state_d      = StIdle;
         best_d       = '0;
         best_valid_d = 1'b0;
         new_record_d = 1'b0;
         rejected_d   = 1'b0;
         attempts_d   = '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (res_valid) begin
                  cap_d     = {res_d2, res_d1, res_d0};
                  verdict_d = VerdUndec;
                  state_d   = StCheck;
               end
            end
            StCheck: begin
               if (range_bad) begin
                  rejected_d   = 1'b1;
                  new_record_d = 1'b0;
                  state_d      = StIdle;
               end else begin
                  rejected_d = 1'b0;
                  state_d    = StCmp2;
               end
            end
            StCmp2: begin
               verdict_d = judge(verdict_q, cap_q[11:8], best_q[11:8]);
               state_d   = StCmp1;
            end
            StCmp1: begin
               verdict_d = judge(verdict_q, cap_q[7:4], best_q[7:4]);
               state_d   = StCmp0;
            end
            StCmp0: begin
               verdict_d = judge(verdict_q, cap_q[3:0], best_q[3:0]);
               state_d   = StCommit;
            end
            StCommit: begin
               // Equal times leave the verdict undecided, so they are not a record.
               if (!best_valid_q || verdict_q == VerdLess) begin
                  best_d       = cap_q;
                  best_valid_d = 1'b1;
                  new_record_d = 1'b1;
               end else begin
                  new_record_d = 1'b0;
               end
               attempts_d = bcd_inc(attempts_q);
               state_d    = StIdle;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= StIdle;
         verdict_q    <= VerdUndec;
         cap_q        <= '0;
         best_q       <= '0;
         best_valid_q <= 1'b0;
         new_record_q <= 1'b0;
         rejected_q   <= 1'b0;
         attempts_q   <= '0;
      end else begin
         state_q      <= state_d;
         verdict_q    <= verdict_d;
         cap_q        <= cap_d;
         best_q       <= best_d;
         best_valid_q <= best_valid_d;
         new_record_q <= new_record_d;
         rejected_q   <= rejected_d;
         attempts_q   <= attempts_d;
      end
   end

   assign best_d2     = best_q[11:8];
   assign best_d1     = best_q[7:4];
   assign best_d0     = best_q[3:0];
   assign best_valid  = best_valid_q;
   assign new_record  = new_record_q;
   assign rejected    = rejected_q;
   assign attempts_d1 = attempts_q[7:4];
   assign attempts_d0 = attempts_q[3:0];

endmodule

// File: tb/tb_reaction_score_keeper.sv
// Bench for reaction_score_keeper: decimal-arithmetic model checked every cycle,
// plus literal expectations after each directed scenario.
module tb_reaction_score_keeper;

   logic       clock = 1'b0;
   logic       reset_n;
   logic       res_valid;
   logic       res_ready;
   logic [3:0] res_d2, res_d1, res_d0;
   logic       clear_best;
   logic [3:0] best_d2, best_d1, best_d0;
   logic       best_valid, new_record, rejected;
   logic [3:0] attempts_d1, attempts_d0;

   int checks = 0;
   int passes = 0;

   reaction_score_keeper dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_d2     (res_d2),
      .res_d1     (res_d1),
      .res_d0     (res_d0),
      .clear_best (clear_best),
      .best_d2    (best_d2),
      .best_d1    (best_d1),
      .best_d0    (best_d0),
      .best_valid (best_valid),
      .new_record (new_record),
      .rejected   (rejected),
      .attempts_d1(attempts_d1),
      .attempts_d0(attempts_d0)
   );

   always #5 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passes++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: times as decimal integers, busy = edges still to go before idle.
   int m_busy = 0;
   int m_best = 0;
   int m_bv   = 0;
   int m_nr   = 0;
   int m_rej  = 0;
   int m_att  = 0;
   int m_c2 = 0, m_c1 = 0, m_c0 = 0;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_busy = 0; m_best = 0; m_bv = 0; m_nr = 0; m_rej = 0; m_att = 0;
      end else if (clear_best) begin
         m_busy = 0; m_best = 0; m_bv = 0; m_nr = 0; m_rej = 0; m_att = 0;
      end else if (m_busy == 0) begin
         if (res_valid) begin
            m_c2 = int'(res_d2); m_c1 = int'(res_d1); m_c0 = int'(res_d0);
            m_busy = 5;
         end
      end else if (m_busy == 5) begin
         if (m_c2 > 9 || m_c1 > 9 || m_c0 > 9 || (m_c2 * 100 + m_c1 * 10 + m_c0) < 10) begin
            m_rej = 1; m_nr = 0; m_busy = 0;
         end else begin
            m_rej = 0; m_busy = 4;
         end
      end else if (m_busy == 1) begin
         if (m_bv == 0 || (m_c2 * 100 + m_c1 * 10 + m_c0) < m_best) begin
            m_best = m_c2 * 100 + m_c1 * 10 + m_c0; m_bv = 1; m_nr = 1;
         end else begin
            m_nr = 0;
         end
         if (m_att < 99) m_att = m_att + 1;
         m_busy = 0;
      end else begin
         m_busy = m_busy - 1;
      end
   end

   // Cycle-by-cycle comparison against the model, away from the rising edge.
   always @(negedge clock) begin
      if (reset_n) begin
         chk("ready", int'(res_ready), (m_busy == 0) ? 1 : 0);
         chk("best_d2", int'(best_d2), m_best / 100);
         chk("best_d1", int'(best_d1), (m_best / 10) % 10);
         chk("best_d0", int'(best_d0), m_best % 10);
         chk("best_valid", int'(best_valid), m_bv);
         chk("new_record", int'(new_record), m_nr);
         chk("rejected", int'(rejected), m_rej);
         chk("att_d1", int'(attempts_d1), m_att / 10);
         chk("att_d0", int'(attempts_d0), m_att % 10);
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!res_ready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!res_ready) chk("idle_timeout", int'(res_ready), 1);
   endtask

   task automatic send(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
      @(negedge clock);
      res_valid = 1'b1; res_d2 = a; res_d1 = b; res_d0 = c;
      @(negedge clock);
      res_valid = 1'b0; res_d2 = 4'hF; res_d1 = 4'hF; res_d0 = 4'hF;
      wait_idle();
   endtask

   int acc;

   initial begin
      reset_n = 1'b0; res_valid = 1'b0; clear_best = 1'b0;
      res_d2 = '0; res_d1 = '0; res_d0 = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_ready", int'(res_ready), 1);
      chk("rst_best", int'({best_valid, best_d2, best_d1, best_d0}), 0);
      chk("rst_flags", int'({new_record, rejected}), 0);
      chk("rst_att", int'({attempts_d1, attempts_d0}), 0);
      @(negedge clock);
      reset_n = 1'b1;

      // 1: first result becomes the best
      send(4'd2, 4'd4, 4'd7);
      chk("t1_best", int'({best_d2, best_d1, best_d0}), 'h247);
      chk("t1_nr_bv", int'({new_record, best_valid}), 'b11);
      chk("t1_att", int'({attempts_d1, attempts_d0}), 'h01);

      // 2: slower, then faster by one hundredth
      send(4'd3, 4'd0, 4'd5);
      chk("t2_best", int'({best_d2, best_d1, best_d0}), 'h247);
      chk("t2_nr", int'(new_record), 0);
      chk("t2_att", int'({attempts_d1, attempts_d0}), 'h02);
      send(4'd2, 4'd4, 4'd6);
      chk("t2b_best", int'({best_d2, best_d1, best_d0}), 'h246);
      chk("t2b_nr", int'(new_record), 1);

      // 3: equal, false start, bad digit
      send(4'd2, 4'd4, 4'd6);
      chk("t3_nr", int'(new_record), 0);
      chk("t3_att", int'({attempts_d1, attempts_d0}), 'h04);
      send(4'd0, 4'd0, 4'd9);
      chk("t3_rej", int'(rejected), 1);
      chk("t3_att_kept", int'({attempts_d1, attempts_d0}), 'h04);
      send(4'd0, 4'd1, 4'd0);
      chk("t3_min_ok", int'({rejected, attempts_d1, attempts_d0}), 'h005);
      send(4'd1, 4'hA, 4'd0);
      chk("t3_hex_rej", int'(rejected), 1);
      chk("t3_hex_best", int'({best_d2, best_d1, best_d0}), 'h010);

      // 4: clear during CMP1, then clear colliding with a valid in idle
      @(negedge clock);
      res_valid = 1'b1; res_d2 = 4'd1; res_d1 = 4'd0; res_d0 = 4'd0;
      @(negedge clock);
      res_valid = 1'b0;
      repeat (2) @(negedge clock);
      clear_best = 1'b1;
      @(negedge clock);
      clear_best = 1'b0;
      chk("t4_ready", int'(res_ready), 1);
      chk("t4_bv_att", int'({best_valid, attempts_d1, attempts_d0}), 0);
      clear_best = 1'b1; res_valid = 1'b1;
      @(negedge clock);
      clear_best = 1'b0; res_valid = 1'b0;
      chk("t4_no_accept", int'(res_ready), 1);

      // 5: saturation of the attempt counter, then back-to-back valid
      for (int i = 0; i < 101; i++) begin
         send(4'd5, 4'd0, 4'd0);
         if (i == 98) chk("t5_att99", int'({attempts_d1, attempts_d0}), 'h99);
      end
      chk("t5_att_sat", int'({attempts_d1, attempts_d0}), 'h99);
      acc = 0;
      res_valid = 1'b1; res_d2 = 4'd4; res_d1 = 4'd0; res_d0 = 4'd0;
      for (int i = 0; i < 30; i++) begin
         if (res_ready) acc++;
         @(negedge clock);
      end
      res_valid = 1'b0;
      chk("t5_throughput", acc, 5);
      wait_idle();

      // 6: asynchronous reset in the middle of CMP2
      @(negedge clock);
      res_valid = 1'b1; res_d2 = 4'd3; res_d1 = 4'd0; res_d0 = 4'd0;
      @(negedge clock);
      res_valid = 1'b0;
      @(negedge clock);
      #2;
      reset_n = 1'b0;
      #1;
      chk("t6_ready", int'(res_ready), 1);
      chk("t6_best", int'({best_valid, best_d2, best_d1, best_d0}), 0);
      chk("t6_flags_att", int'({new_record, rejected, attempts_d1, attempts_d0}), 0);
      @(negedge clock);
      reset_n = 1'b1;
      send(4'd9, 4'd9, 4'd9);
      chk("t6_999_record", int'({new_record, best_d2, best_d1, best_d0}), 'h1999);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
